// File: rtl/alu_logic_pipe.sv
// alu_logic_pipe: two-stage valid/ready pipelined bitwise logic unit.
// S1 registers the operands and op. S2 registers the result and the zero/all-ones flags.
// The outputs are driven only from S2 registers.
module alu_logic_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ones
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_zero;
    logic             s2_ones;

    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] res_next;

    // Stage load enables. A held S2 holds S1, and in_ready follows from that.
    always_comb begin
        s2_load  = !s2_valid || out_ready;
        s1_load  = !s1_valid || s2_load;
        in_ready = s1_load;
    end

    // The logic operation is evaluated between S1 and S2.
    always_comb begin
        res_next = '0;
        unique case (s1_op)
            OP_AND:  res_next = s1_a & s1_b;
            OP_OR:   res_next = s1_a | s1_b;
            OP_XOR:  res_next = s1_a ^ s1_b;
            OP_NOR:  res_next = ~(s1_a | s1_b);
            OP_ANDN: res_next = s1_a & ~s1_b;
            OP_ORN:  res_next = s1_a | ~s1_b;
            OP_PASS: res_next = s1_a;
            OP_NOT:  res_next = ~s1_a;
            default: res_next = '0;
        endcase
    end

    // S1 captures the operands. Data is loaded only when in_valid is high,
    // so idle X values on the inputs never reach the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_op <= in_op;
            end
        end
    end

    // S2 captures the result and the flags. They hold while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_zero   <= 1'b0;
            s2_ones   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= res_next;
                s2_zero   <= ~|res_next;
                s2_ones   <= &res_next;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_zero   = s2_zero;
    assign out_ones   = s2_ones;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Directed bench for alu_logic_pipe.
// A negedge monitor matches every output transfer, in order, against a queue of expected values.
// It also checks that the outputs stay stable while out_ready is low.
module tb_alu_logic_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_ones;

    // Narrow and wide builds, driven with held inputs.
    logic        w1_in_ready, w1_out_valid, w1_zero, w1_ones;
    logic [0:0]  w1_a = '0, w1_b = '0, w1_res;
    logic [2:0]  w1_op = '0;
    logic        w64_in_ready, w64_out_valid, w64_zero, w64_ones;
    logic [63:0] w64_a = '0, w64_b = '0, w64_res;
    logic [2:0]  w64_op = '0;

    int checks = 0;
    int errors = 0;
    logic [33:0] expq[$];
    logic        held = 1'b0;
    logic [33:0] held_val;
    logic        rnd_done;

    always #5 clk = ~clk;

    alu_logic_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
        .out_ones(out_ones)
    );

    alu_logic_pipe #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst(rst), .in_valid(1'b1), .in_ready(w1_in_ready),
        .in_a(w1_a), .in_b(w1_b), .in_op(w1_op), .out_valid(w1_out_valid),
        .out_ready(1'b1), .out_result(w1_res), .out_zero(w1_zero),
        .out_ones(w1_ones)
    );

    alu_logic_pipe #(.WIDTH(64)) dut_w64 (
        .clk(clk), .rst(rst), .in_valid(1'b1), .in_ready(w64_in_ready),
        .in_a(w64_a), .in_b(w64_b), .in_op(w64_op), .out_valid(w64_out_valid),
        .out_ready(1'b1), .out_result(w64_res), .out_zero(w64_zero),
        .out_ones(w64_ones)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        logic [31:0] r;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~(a | b);
            3'd4: r = a & ~b;
            3'd5: r = a | ~b;
            3'd6: r = a;
            default: r = ~a;
        endcase
        return {r, (r == 32'h0), (r == 32'hFFFF_FFFF)};
    endfunction

    // Present one transaction and wait, with a bound, until it is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [33:0] exp);
        int n;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                expq.push_back(exp);
                break;
            end
            n++;
            if (n > 100) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_a = 'x; in_b = 'x; in_op = 'x;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(expq.size()), 64'd0);
    endtask

    // Output monitor: in-order scoreboard plus a stability check on stalls.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held && out_valid)
                chk("stall_hold", {30'd0, out_result, out_zero, out_ones}, {30'd0, held_val});
            if (out_valid && out_ready) begin
                if (expq.size() == 0)
                    chk("unexpected_out", 64'd1, 64'd0);
                else
                    chk("out_data", {30'd0, out_result, out_zero, out_ones},
                        {30'd0, expq.pop_front()});
            end
            held     = out_valid && !out_ready;
            held_val = {out_result, out_zero, out_ones};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_flags", {62'd0, out_zero, out_ones}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Single transaction and its latency.
        @(posedge clk); #1;
        expq.push_back({32'hFFFF_0000, 1'b0, 1'b0});
        in_a = 32'hF0F0_0000; in_b = 32'h0F0F_0000; in_op = 3'b001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = 'x; in_b = 'x; in_op = 'x;
        @(negedge clk);
        chk("lat_edge1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_edge2_valid", 64'(out_valid), 64'd1);
        chk("single_result", 64'(out_result), 64'hFFFF_0000);
        drain("drain_single");

        // All eight ops back-to-back.
        @(posedge clk); #1;
        send(32'hAAAA_AAAA, 32'hCCCC_CCCC, 3'd0, {32'h8888_8888, 2'b00});
        send(32'hAAAA_AAAA, 32'hCCCC_CCCC, 3'd1, {32'hEEEE_EEEE, 2'b00});
        send(32'hAAAA_AAAA, 32'hCCCC_CCCC, 3'd2, {32'h6666_6666, 2'b00});
        send(32'hAAAA_AAAA, 32'hCCCC_CCCC, 3'd3, {32'h1111_1111, 2'b00});
        send(32'hAAAA_AAAA, 32'hCCCC_CCCC, 3'd4, {32'h2222_2222, 2'b00});
        send(32'hAAAA_AAAA, 32'hCCCC_CCCC, 3'd5, {32'hBBBB_BBBB, 2'b00});
        send(32'hAAAA_AAAA, 32'hCCCC_CCCC, 3'd6, {32'hAAAA_AAAA, 2'b00});
        send(32'hAAAA_AAAA, 32'hCCCC_CCCC, 3'd7, {32'h5555_5555, 2'b00});
        drain("drain_sweep");

        // Flag cases.
        @(posedge clk); #1;
        send(32'h1234_5678, 32'h1234_5678, 3'b010, {32'h0, 2'b10});
        send(32'h0, 32'h0, 3'b011, {32'hFFFF_FFFF, 2'b01});
        drain("drain_flags");

        // Backpressure: four transactions against a stalled output.
        @(posedge clk); #1;
        out_ready = 1'b0;
        fork
            begin
                send(32'h1111_1111, 32'hFFFF_0000, 3'd0, {32'h1111_0000, 2'b00});
                send(32'h2222_2222, 32'hFFFF_0000, 3'd0, {32'h2222_0000, 2'b00});
                @(negedge clk);
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                send(32'h3333_3333, 32'hFFFF_0000, 3'd0, {32'h3333_0000, 2'b00});
                send(32'h0000_4444, 32'hFFFF_0000, 3'd0, {32'h0, 2'b10});
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_bp");

        // Asynchronous reset with both stages full.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'hDEAD_BEEF, 32'h0, 3'd6, {32'hDEAD_BEEF, 2'b00});
        send(32'h0, 32'h0, 3'd7, {32'hFFFF_FFFF, 2'b01});
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_result", 64'(out_result), 64'd0);
        chk("midrst_flags", {62'd0, out_zero, out_ones}, 64'd0);
        expq.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", 64'(out_valid), 64'd0);
        end

        // Narrow and wide builds.
        w1_a = 1'b1; w1_b = 1'b0; w1_op = 3'b000;
        w64_a = 64'hFFFF_0000_0000_FFFF; w64_b = '0; w64_op = 3'b111;
        repeat (3) @(negedge clk);
        chk("w1_and", {61'd0, w1_out_valid, w1_zero, w1_ones}, {61'd0, 3'b110});
        chk("w1_and_res", 64'(w1_res), 64'd0);
        chk("w64_not", w64_res, 64'h0000_FFFF_FFFF_0000);
        chk("w64_not_flags", {62'd0, w64_zero, w64_ones}, 64'd0);
        w1_op = 3'b101;
        w64_a = '1; w64_op = 3'b110;
        repeat (3) @(negedge clk);
        chk("w1_orn", {61'd0, w1_out_valid, w1_zero, w1_ones}, {61'd0, 3'b101});
        chk("w1_orn_res", 64'(w1_res), 64'd1);
        chk("w64_pass", w64_res, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("w64_pass_flags", {62'd0, w64_zero, w64_ones}, 64'd1);

        // Random traffic with random gaps and random backpressure.
        rnd_done = 1'b0;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [31:0] a, b;
                    logic [2:0]  op;
                    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
                    if (i % 7 == 3) b = a;
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(a, b, op, model(a, b, op));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain("drain_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
